// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
//   Flow-controlled pipeline stage register with a 2-entry skid buffer.
//   Carries {ctrl, data0, data1, rd} from one core stage to the next under a
//   valid/ready handshake. The entry presented downstream always lives in the
//   head register. A second (skid) register absorbs the one entry that can
//   arrive while the head is back-pressured. This keeps in_ready a plain flop
//   output with no combinational path from out_ready.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   flush            synchronous kill of held and incoming entries
//   in_valid/ready   upstream handshake (in_ready is registered)
//   in_ctrl/data0/data1/rd   upstream payload
//   out_valid/ready  downstream handshake
//   out_ctrl/data0/data1/rd  head payload (out_ctrl squashed to 0 when idle)
//   occupancy        number of entries held (0..2)
//   stall_cycles     saturating count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------

// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_stage_skid_satcnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end
endmodule

module pipe_stage_skid #(
   parameter int DATA_W      = 64,
   parameter int CTRL_W      = 2,
   parameter int RD_W        = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data0,
   input  logic [DATA_W-1:0]      in_data1,
   input  logic [RD_W-1:0]        in_rd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data0,
   output logic [DATA_W-1:0]      out_data1,
   output logic [RD_W-1:0]        out_rd,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data0;
      logic [DATA_W-1:0] data1;
      logic [RD_W-1:0]   rd;
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   ent_t       head_q, skid_q, in_ent;
   logic       out_valid_q, in_ready_q;
   logic [1:0] occ_q, occ_d;
   logic       in_fire, out_fire;
   logic       head_ld_in, head_ld_skid, skid_ld;

   assign in_ent   = '{ctrl: in_ctrl, data0: in_data0, data1: in_data1, rd: in_rd};
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Next-state and load-enable decode. Flush overrides every transition and
   // suppresses all loads, so an entry accepted in the flush cycle is dropped.
   always_comb begin
      state_d      = state_q;
      head_ld_in   = 1'b0;
      head_ld_skid = 1'b0;
      skid_ld      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  head_ld_in = 1'b1;
                  state_d    = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  // Head leaves as the new entry arrives: no bubble.
                  head_ld_in = 1'b1;
               end else if (in_fire) begin
                  skid_ld = 1'b1;
                  state_d = TWO;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so in_valid cannot fire.
               if (out_fire) begin
                  head_ld_skid = 1'b1;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      case (state_d)
         ONE:     occ_d = 2'd1;
         TWO:     occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
   end

   // State plus its decoded outputs, all registered together so out_valid,
   // in_ready and occupancy come straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= (state_d != EMPTY);
         in_ready_q  <= (state_d != TWO);
         occ_q       <= occ_d;
      end
   end

   // Payload registers. On flush they keep stale contents; out_ctrl squashing
   // makes that harmless.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         if (head_ld_in)
            head_q <= in_ent;
         else if (head_ld_skid)
            head_q <= skid_q;
         if (skid_ld)
            skid_q <= in_ent;
      end
   end

   pipe_stage_skid_satcnt #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid_q & ~out_ready),
      .count (stall_cycles)
   );

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign occupancy = occ_q;
   // Bubble squash: an invalid slot never carries live control bits.
   assign out_ctrl  = out_valid_q ? head_q.ctrl : '0;
   assign out_data0 = head_q.data0;
   assign out_data1 = head_q.data1;
   assign out_rd    = head_q.rd;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
   localparam int DW = 64, CW = 2, RW = 5, SW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data0 = '0, in_data1 = '0;
   logic [RW-1:0] in_rd = '0;
   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data0, out_data1;
   logic [RW-1:0] out_rd;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_cycles;

   int n_cmp = 0, n_bad = 0;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .STALL_CNT_W(SW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data0(in_data0), .in_data1(in_data1), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data0(out_data0), .out_data1(out_data1), .out_rd(out_rd),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus plus the outputs expected right after the edge.
   // mode: 0 = payload not checked, 1 = payload checked, 2 = payload must be zero
   typedef struct {
      logic          rst, fl, iv, ordy;
      logic [CW-1:0] ictrl;
      logic [DW-1:0] id1;
      logic [RW-1:0] ird;
      logic          ov, ir;
      logic [1:0]    occ;
      logic [CW-1:0] octrl;
      int            mode;
      logic [DW-1:0] od1;
      logic [RW-1:0] ord;
      logic [SW-1:0] stall;
   } vec_t;

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy,
                               logic [CW-1:0] ictrl, logic [DW-1:0] id1, logic [RW-1:0] ird,
                               logic ov, logic ir, logic [1:0] occ, logic [CW-1:0] octrl,
                               int mode, logic [DW-1:0] od1, logic [RW-1:0] ord,
                               logic [SW-1:0] stall);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy;
      v.ictrl = ictrl; v.id1 = id1; v.ird = ird;
      v.ov = ov; v.ir = ir; v.occ = occ; v.octrl = octrl;
      v.mode = mode; v.od1 = od1; v.ord = ord; v.stall = stall;
      return v;
   endfunction

   // data0 is tied to data1 with a fixed upper pattern so both words are exercised.
   function automatic logic [DW-1:0] d0_of(logic [DW-1:0] d1);
      return {32'hD0D0_D0D0, d1[31:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst; flush = v.fl; in_valid = v.iv; out_ready = v.ordy;
      in_ctrl = v.ictrl; in_data1 = v.id1; in_data0 = d0_of(v.id1); in_rd = v.ird;
      @(posedge clk); #1;
      chk("out_valid", 64'(out_valid), 64'(v.ov));
      chk("in_ready", 64'(in_ready), 64'(v.ir));
      chk("occupancy", 64'(occupancy), 64'(v.occ));
      chk("out_ctrl", 64'(out_ctrl), 64'(v.octrl));
      chk("stall_cycles", 64'(stall_cycles), 64'(v.stall));
      if (v.mode == 1) begin
         chk("out_data0", out_data0, d0_of(v.od1));
         chk("out_data1", out_data1, v.od1);
         chk("out_rd", 64'(out_rd), 64'(v.ord));
      end else if (v.mode == 2) begin
         chk("out_data0 zero", out_data0, 64'h0);
         chk("out_data1 zero", out_data1, 64'h0);
         chk("out_rd zero", 64'(out_rd), 64'h0);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two entries.
   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d0, d1;
      logic [RW-1:0] rd;
   } ent_t;
   ent_t q[$];
   int   m_stall;

   task automatic rnd_cycle(input bit force_rst);
      bit   m_ov, m_ir;
      ent_t e;
      reset     = force_rst | ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = CW'($urandom);
      in_data0  = {$urandom, $urandom};
      in_data1  = {$urandom, $urandom};
      in_rd     = RW'($urandom);
      e.c = in_ctrl; e.d0 = in_data0; e.d1 = in_data1; e.rd = in_rd;
      m_ov = (q.size() > 0);
      m_ir = (q.size() < 2);
      @(posedge clk); #1;
      if (reset) begin
         q.delete();
         m_stall = 0;
      end else begin
         if (m_ov && !out_ready && m_stall < (2**SW - 1)) m_stall++;
         if (flush) q.delete();
         else begin
            if (m_ov && out_ready) void'(q.pop_front());
            if (in_valid && m_ir) q.push_back(e);
         end
      end
      chk("rnd out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("rnd occupancy", 64'(occupancy), 64'(q.size()));
      chk("rnd stall_cycles", 64'(stall_cycles), 64'(m_stall));
      if (q.size() > 0) begin
         chk("rnd out_ctrl", 64'(out_ctrl), 64'(q[0].c));
         chk("rnd out_data0", out_data0, q[0].d0);
         chk("rnd out_data1", out_data1, q[0].d1);
         chk("rnd out_rd", 64'(out_rd), 64'(q[0].rd));
      end else begin
         chk("rnd out_ctrl squash", 64'(out_ctrl), 64'h0);
      end
   endtask

   vec_t tbl[$];

   initial begin
      // Reset, then a 4-entry stream with downstream always ready.
      tbl.push_back(mk(1,0,0,0, 0,0,0,       0,1,0,0, 2,0,0, 0));
      tbl.push_back(mk(1,0,0,0, 0,0,0,       0,1,0,0, 2,0,0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,1,1, 3,64'h10+i,RW'(1+i), 1,1,1,3, 1,64'h10+i,RW'(1+i), 0));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 0));
      // Back-pressure: A then B held, then drained in order.
      tbl.push_back(mk(0,0,1,0, 1,64'hA,5,   1,1,1,1, 1,64'hA,5, 0));
      tbl.push_back(mk(0,0,1,0, 2,64'hB,6,   1,0,2,1, 1,64'hA,5, 1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,       1,0,2,1, 1,64'hA,5, 2));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       1,1,1,2, 1,64'hB,6, 2));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 2));
      // Flush while TWO with C offered; C must never appear.
      tbl.push_back(mk(0,0,1,0, 3,64'h20,7,  1,1,1,3, 1,64'h20,7, 2));
      tbl.push_back(mk(0,0,1,0, 1,64'h21,8,  1,0,2,3, 1,64'h20,7, 3));
      tbl.push_back(mk(0,1,1,0, 3,64'h2C,9,  0,1,0,0, 0,0,0, 4));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 4));
      // Flush in ONE with an accepted entry: the entry is discarded.
      tbl.push_back(mk(0,0,1,0, 2,64'h50,10, 1,1,1,2, 1,64'h50,10, 4));
      tbl.push_back(mk(0,1,1,1, 3,64'h51,11, 0,1,0,0, 0,0,0, 4));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 4));
      // Simultaneous push and pop in ONE: D replaces head, no bubble.
      tbl.push_back(mk(0,0,1,0, 1,64'h30,12, 1,1,1,1, 1,64'h30,12, 4));
      tbl.push_back(mk(0,0,1,1, 2,64'h3D,13, 1,1,1,2, 1,64'h3D,13, 4));
      tbl.push_back(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 4));
      foreach (tbl[i]) apply(tbl[i]);

      // Stall counter saturation: hold one entry for 10 stalled cycles.
      apply(mk(0,0,1,0, 3,64'h40,14, 1,1,1,3, 1,64'h40,14, 4));
      for (int k = 1; k <= 10; k++)
         apply(mk(0,0,0,0, 0,0,0, 1,1,1,3, 1,64'h40,14, SW'((4 + k > 7) ? 7 : 4 + k)));
      apply(mk(0,1,0,0, 0,0,0, 0,1,0,0, 0,0,0, 7));   // flush keeps the count
      apply(mk(0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 7));
      apply(mk(1,0,0,0, 0,0,0, 0,1,0,0, 2,0,0, 0));   // reset clears it

      // Reset while TWO with in_valid high, then a clean first entry.
      apply(mk(0,0,1,0, 1,64'h60,15, 1,1,1,1, 1,64'h60,15, 0));
      apply(mk(0,0,1,0, 2,64'h61,16, 1,0,2,1, 1,64'h60,15, 1));
      apply(mk(1,0,1,0, 3,64'h62,17, 0,1,0,0, 2,0,0, 0));
      apply(mk(0,0,1,1, 2,64'h70,18, 1,1,1,2, 1,64'h70,18, 0));
      apply(mk(0,0,0,1, 0,0,0,       0,1,0,0, 0,0,0, 0));

      // Randomized traffic against the FIFO model.
      m_stall = 0;
      rnd_cycle(1'b1);
      for (int i = 0; i < 600; i++) rnd_cycle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register for the 5-stage core. Generalises the fixed MEM/WB latch.
- Carries a control field, two data words and a destination register index, with a valid/ready handshake.
- Has a 2-entry skid buffer so back-pressure does not create a combinational ready path.
- Supports synchronous flush, bubble squashing and an occupancy/stall counter.
- Instantiated between any two stages (IF/ID through MEM/WB).

Parameters:
- DATA_W, 64, width of each data word (data0, data1)
- CTRL_W, 2, width of control bit field (e.g. RegWrite, MemtoReg)
- RD_W, 5, destination register index width
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data0  in  DATA_W  upstream data word 0 (e.g. memory read data)
- in_data1  in  DATA_W  upstream data word 1 (e.g. ALU result)
- in_rd  in  RD_W  upstream destination register
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts entry
- out_ctrl  out  CTRL_W  control bits; forced all-zero whenever out_valid=0
- out_data0  out  DATA_W  head entry data word 0
- out_data1  out  DATA_W  head entry data word 1
- out_rd  out  RD_W  head entry destination register
- occupancy  out  2  entries held (0, 1 or 2)
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset and clocking:
  - Single clock domain; reset is synchronous and active-high.
  - On reset: state=EMPTY; out_valid=0; in_ready=1; occupancy=0; stall_cycles=0; out_ctrl, out_data0, out_data1, out_rd all zero; skid storage zeroed.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready is a registered output (= !skid_full) and never depends combinationally on out_ready.
  - out_* are driven directly from the head register.
- States:
  - EMPTY: out_valid=0, in_ready=1. in_fire -> head<=in, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - in_fire & out_fire -> head<=in, stay ONE.
    - in_fire only -> skid<=in, go to TWO.
    - out_fire only -> go to EMPTY.
    - Neither -> hold.
  - TWO: out_valid=1, in_ready=0.
    - out_fire -> head<=skid, go to ONE.
    - Otherwise hold; in_valid is ignored.
- Latency and ordering:
  - 1 cycle from in_fire to out_valid when EMPTY.
  - Strict FIFO order is preserved; no entry is dropped or duplicated except by flush.
- Flush:
  - Priority: reset > flush > normal operation.
  - Effect: next state EMPTY, occupancy=0, in_ready=1. A same-cycle in_fire entry is discarded, not loaded.
  - A same-cycle out_fire is still counted as consumed by downstream.
  - Data registers may hold stale values, but out_ctrl reads zero, so a flushed entry can never assert RegWrite.
- Bubble squash: out_ctrl = head_ctrl when out_valid=1, else all zeros.
- occupancy: 0/1/2 for EMPTY/ONE/TWO, registered and updated with the state.
- stall_cycles:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W-1 with no wrap.
  - Cleared only by reset; flush does not clear it.
- Width rule: all payload fields are copied bit-exact; no sign extension or truncation.

Test Plan:
- Reset then stream: assert reset 2 cycles; drive in_valid=1 for 4 cycles with in_data1=0x10..0x13, in_rd=1..4, in_ctrl=2'b11, out_ready=1 -> out_valid rises 1 cycle after the first in_fire; outputs appear in order 0x10..0x13, one per cycle; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0 while sending A(0xA) then B(0xB) -> occupancy 1 then 2; in_ready=0 after B; out_data1=0xA held; stall_cycles increments each cycle. Raise out_ready -> A then B delivered; in_ready returns to 1 the cycle after A pops.
- Flush while TWO: two entries held, in_valid=1 with C, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears at the output.
- Stall counter saturation: with STALL_CNT_W=3, hold one entry with out_ready=0 for 10 cycles -> stall_cycles reads 7 and stays 7; flush leaves it at 7; reset clears it to 0.
- Reset mid-operation: occupancy=2 and in_valid=1 when reset asserts for 1 cycle -> next cycle all outputs zero, state EMPTY; the first post-reset entry is delivered correctly.
- Simultaneous in/out in ONE: a new entry D arrives in the same cycle out_fire pops the head -> head<=D, occupancy stays 1, no bubble; out_data1=D on the next cycle.
